core_alu_arbiter: RTL and testbench

Shares one core_alu instance between two requesters: port 0 is the execute stage and port 1 is the branch/address unit. Each port has a valid/ready request channel and a valid/ready response channel. A round-robin grant picks one request, registers its operands, and evaluates the ALU for one cycle. The result is held on the granted port's response channel until that port accepts it. The block sits between decode/issue and writeback, replacing direct ALU instantiation in the core top.

---
 rtl/core_alu_arbiter_pkg.sv | 45 ++++
 rtl/core_alu.sv | 52 +++++
 rtl/core_alu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_core_alu_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// core_alu_arbiter_pkg
//   Shared definitions for the ALU arbiter slice:
//     - default data / function-code widths
//     - ALU function codes understood by core_alu
//     - arbiter FSM encoding and requester port ids
//     - debug struct exposing the arbiter's internal state
// -----------------------------------------------------------------------------
package core_alu_arbiter_pkg;

  // Operand/result width and ALU function-code width.
  localparam int ALU_DATA_W = 32;
  localparam int ALU_FUNC_W = 4;

  // ALU function codes. Any code not listed here evaluates to zero.
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_ADD  = 4'd0;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_SUB  = 4'd1;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_SLL  = 4'd2;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_SLT  = 4'd3;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_SLTU = 4'd4;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_XOR  = 4'd5;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_SRL  = 4'd6;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_SRA  = 4'd7;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_OR   = 4'd8;
  localparam logic [ALU_FUNC_W-1:0] ALU_FUNC_AND  = 4'd9;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EVAL = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  // Requester port ids.
  localparam logic PORT_EXEC   = 1'b0;  // execute stage
  localparam logic PORT_BRANCH = 1'b1;  // branch/address unit

  // Internal state made visible for checkers.
  typedef struct packed {
    arb_state_t state;
    logic       prio;
    logic       grant_id;
  } arb_dbg_t;

endpackage

// File: rtl/core_alu.sv
// -----------------------------------------------------------------------------
// core_alu
//   Combinational integer ALU. The output is forced to zero whenever eval_en
//   is low so that downstream registers only ever see a result in the cycle
//   the arbiter evaluates.
//
// Ports:
//   eval_en  in   1       evaluate this cycle
//   opnum1   in   DATA_W  operand 1
//   opnum2   in   DATA_W  operand 2 (shift amount taken from bits [4:0])
//   func     in   FUNC_W  function code (ALU_FUNC_*)
//   res      out  DATA_W  result, zero when eval_en=0 or func is unknown
// -----------------------------------------------------------------------------
module core_alu
  import core_alu_arbiter_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int FUNC_W = ALU_FUNC_W
) (
  input  logic              eval_en,
  input  logic [DATA_W-1:0] opnum1,
  input  logic [DATA_W-1:0] opnum2,
  input  logic [FUNC_W-1:0] func,
  output logic [DATA_W-1:0] res
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] res_c;

  // Shifts only honour the low five bits of operand 2.
  assign shamt = opnum2[4:0];

  always_comb begin
    res_c = '0;
    case (func)
      FUNC_W'(ALU_FUNC_ADD):  res_c = opnum1 + opnum2;
      FUNC_W'(ALU_FUNC_SUB):  res_c = opnum1 - opnum2;
      FUNC_W'(ALU_FUNC_SLL):  res_c = opnum1 << shamt;
      FUNC_W'(ALU_FUNC_SLT):  res_c = DATA_W'($signed(opnum1) < $signed(opnum2));
      FUNC_W'(ALU_FUNC_SLTU): res_c = DATA_W'(opnum1 < opnum2);
      FUNC_W'(ALU_FUNC_XOR):  res_c = opnum1 ^ opnum2;
      FUNC_W'(ALU_FUNC_SRL):  res_c = opnum1 >> shamt;
      FUNC_W'(ALU_FUNC_SRA):  res_c = $unsigned($signed(opnum1) >>> shamt);
      FUNC_W'(ALU_FUNC_OR):   res_c = opnum1 | opnum2;
      FUNC_W'(ALU_FUNC_AND):  res_c = opnum1 & opnum2;
      default:                res_c = '0;
    endcase
  end

  assign res = eval_en ? res_c : '0;

endmodule

// File: rtl/core_alu_arbiter.sv
// -----------------------------------------------------------------------------
// core_alu_arbiter
//   Shares a single core_alu between the execute stage (port 0) and the
//   branch/address unit (port 1). One operation is in flight at a time:
//     IDLE : round-robin grant, capture operands of the granted request
//     EVAL : ALU evaluates from the captured registers, result registered
//     RESP : result presented to the granted port until it accepts
//
// Handshake rules (both channels): a transfer happens in a cycle where valid
// and ready are both high. reqN_ready is combinational from reqN_valid, so a
// requester must never derive valid from ready. Once rspN_valid rises it
// stays high with rspN_res stable until rspN_ready is seen.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req{0,1}_valid/ready              request channel handshake
//   req{0,1}_opnum1/opnum2/func       request operands and ALU function
//   rsp{0,1}_valid/ready              response channel handshake
//   rsp{0,1}_res                      result (zero when not valid)
//   busy                              FSM not in IDLE
//   dbg                               state, round-robin priority, grant id
// -----------------------------------------------------------------------------
module core_alu_arbiter
  import core_alu_arbiter_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int FUNC_W = ALU_FUNC_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_opnum1,
  input  logic [DATA_W-1:0] req0_opnum2,
  input  logic [FUNC_W-1:0] req0_func,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_res,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_opnum1,
  input  logic [DATA_W-1:0] req1_opnum2,
  input  logic [FUNC_W-1:0] req1_func,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_res,

  output logic              busy,
  output arb_dbg_t          dbg
);

  arb_state_t        state, state_next;
  logic              prio;
  logic              grant_id;
  logic              grant;
  logic              req_fire;
  logic              rsp_fire;
  logic              eval_en;
  logic [DATA_W-1:0] op1_q, op2_q, result_q;
  logic [FUNC_W-1:0] func_q;
  logic [DATA_W-1:0] alu_res;

  // ---------------------------------------------------------------------------
  // Grant selection: a lone requester always wins; on contention the port
  // named by prio wins. prio flips to the other port after every grant, so
  // continuous contention alternates.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant = prio;
    if (req0_valid && !req1_valid) begin
      grant = PORT_EXEC;
    end else if (!req0_valid && req1_valid) begin
      grant = PORT_BRANCH;
    end
  end

  // Ready is masked during reset so nothing looks accepted while rst is high.
  assign req0_ready = !rst && (state == ARB_IDLE) && (grant == PORT_EXEC)   && req0_valid;
  assign req1_ready = !rst && (state == ARB_IDLE) && (grant == PORT_BRANCH) && req1_valid;
  assign req_fire   = req0_ready || req1_ready;

  // Only the granted port's ready can complete a response.
  assign rsp_fire = (state == ARB_RESP) &&
                    ((grant_id == PORT_BRANCH) ? rsp1_ready : rsp0_ready);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: if (req_fire) state_next = ARB_EVAL;
      ARB_EVAL: state_next = ARB_RESP;
      ARB_RESP: if (rsp_fire) state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: operand capture on request handshake, result capture
  // in EVAL. result_q is only visible on the outputs during RESP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= PORT_EXEC;
      grant_id <= PORT_EXEC;
      op1_q    <= '0;
      op2_q    <= '0;
      func_q   <= '0;
      result_q <= '0;
    end else begin
      if (req_fire) begin
        grant_id <= grant;
        prio     <= ~grant;
        op1_q    <= (grant == PORT_BRANCH) ? req1_opnum1 : req0_opnum1;
        op2_q    <= (grant == PORT_BRANCH) ? req1_opnum2 : req0_opnum2;
        func_q   <= (grant == PORT_BRANCH) ? req1_func   : req0_func;
      end
      if (state == ARB_EVAL) begin
        result_q <= alu_res;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared ALU
  // ---------------------------------------------------------------------------
  assign eval_en = (state == ARB_EVAL);

  core_alu #(
    .DATA_W (DATA_W),
    .FUNC_W (FUNC_W)
  ) u_alu (
    .eval_en (eval_en),
    .opnum1  (op1_q),
    .opnum2  (op2_q),
    .func    (func_q),
    .res     (alu_res)
  );

  // ---------------------------------------------------------------------------
  // Response outputs: only the granted port sees valid and a non-zero result.
  // ---------------------------------------------------------------------------
  assign rsp0_valid = (state == ARB_RESP) && (grant_id == PORT_EXEC);
  assign rsp1_valid = (state == ARB_RESP) && (grant_id == PORT_BRANCH);
  assign rsp0_res   = rsp0_valid ? result_q : '0;
  assign rsp1_res   = rsp1_valid ? result_q : '0;

  assign busy = (state != ARB_IDLE);

  assign dbg.state    = state;
  assign dbg.prio     = prio;
  assign dbg.grant_id = grant_id;

endmodule

// File: tb/tb_core_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_alu_arbiter
//   Directed self-checking bench for core_alu_arbiter. Inputs change 1 ns
//   after the rising edge; outputs are checked 2 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_core_alu_arbiter;
  import core_alu_arbiter_pkg::*;

  localparam int DATA_W = 32;
  localparam int FUNC_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [DATA_W-1:0] req0_opnum1, req0_opnum2, rsp0_res;
  logic [FUNC_W-1:0] req0_func;
  logic              req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] req1_opnum1, req1_opnum2, rsp1_res;
  logic [FUNC_W-1:0] req1_func;
  logic              busy;
  arb_dbg_t          dbg;

  int errors = 0;
  int checks = 0;

  core_alu_arbiter #(.DATA_W(DATA_W), .FUNC_W(FUNC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_opnum1 (req0_opnum1),
    .req0_opnum2 (req0_opnum2),
    .req0_func   (req0_func),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_res    (rsp0_res),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_opnum1 (req1_opnum1),
    .req1_opnum2 (req1_opnum2),
    .req1_func   (req1_func),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_res    (rsp1_res),
    .busy        (busy),
    .dbg         (dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_opnum1 = '0; req0_opnum2 = '0; req0_func = '0;
    req1_valid = 1'b0; req1_opnum1 = '0; req1_opnum2 = '0; req1_func = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  // Issue one op on port 0 from IDLE with port 1 quiet; returns what was seen
  // at the request cycle (acc) and two cycles later (vld/res). Leaves the DUT
  // in IDLE after the response handshake.
  task automatic drive_op0(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [FUNC_W-1:0] f, output logic acc,
                           output logic vld, output logic [DATA_W-1:0] res);
    req0_opnum1 = a; req0_opnum2 = b; req0_func = f;
    req0_valid = 1'b1; rsp0_ready = 1'b1;
    #1;
    acc = req0_ready;
    step();
    req0_valid = 1'b0;
    step();
    #1;
    vld = rsp0_valid;
    res = rsp0_res;
    step();
    rsp0_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b expected 0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b expected 0", req1_ready); end
      checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b%b expected 00", rsp0_valid, rsp1_valid); end
      checks++; if (rsp0_res !== '0 || rsp1_res !== '0) begin errors++; $display("FAIL reset_rsp_res: got %h/%h expected 0/0", rsp0_res, rsp1_res); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (dbg !== '{state: ARB_IDLE, prio: 1'b0, grant_id: 1'b0}) begin errors++; $display("FAIL reset_dbg: got %h expected 0", dbg); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    req0_opnum1 = 32'h0000_0005; req0_opnum2 = 32'h0000_0003; req0_func = ALU_FUNC_ADD;
    req0_valid = 1'b1; rsp0_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_req0_ready_T: got %b expected 1", req0_ready); end
    step();
    req0_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL single_T1: busy=%b rsp0_valid=%b expected busy=1 valid=0", busy, rsp0_valid); end
    step();
    #1;
    checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL single_rsp0_valid_T2: got %b expected 1", rsp0_valid); end
    checks++; if (rsp0_res !== 32'h0000_0008) begin errors++; $display("FAIL single_rsp0_res: got %h expected 00000008", rsp0_res); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL single_rsp1_valid: got %b expected 0", rsp1_valid); end
    step();
    #1;
    checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_after_rsp: rsp0_valid=%b busy=%b expected 0 0", rsp0_valid, busy); end
    rsp0_ready = 1'b0;
  endtask

  task automatic test_contention();
    logic exp_id;
    logic [DATA_W-1:0] got_res, exp_res;
    idle_inputs();
    do_reset(1);
    req0_opnum1 = 32'd10;          req0_opnum2 = 32'd3;          req0_func = ALU_FUNC_SUB;
    req1_opnum1 = 32'hFFFF_FFFF;   req1_opnum2 = 32'h0000_0001;  req1_func = ALU_FUNC_SLT;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_id  = (i % 2 == 1);
      exp_res = exp_id ? 32'h0000_0001 : 32'h0000_0007;
      #1;
      checks++; if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_grant_%0d: ready1/0=%b%b expected port %0d", i, req1_ready, req0_ready, exp_id); end
      step();
      checks++; if (dbg.grant_id !== exp_id) begin errors++; $display("FAIL contention_grant_id_%0d: got %b expected %b", i, dbg.grant_id, exp_id); end
      step();
      #1;
      got_res = exp_id ? rsp1_res : rsp0_res;
      checks++; if ({rsp1_valid, rsp0_valid} !== (exp_id ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_rsp_valid_%0d: got %b%b expected port %0d", i, rsp1_valid, rsp0_valid, exp_id); end
      checks++; if (got_res !== exp_res) begin errors++; $display("FAIL contention_res_%0d: got %h expected %h", i, got_res, exp_res); end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++; if (dbg.prio !== 1'b0 || dbg.state !== ARB_IDLE) begin errors++; $display("FAIL contention_end: prio=%b state=%0d expected prio=0 IDLE", dbg.prio, dbg.state); end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    req1_opnum1 = 32'h8000_0000; req1_opnum2 = 32'h0000_0004; req1_func = ALU_FUNC_SRA;
    req1_valid = 1'b1; rsp1_ready = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_req1_ready: got %b expected 1", req1_ready); end
    step();
    req1_valid = 1'b0;
    req0_opnum1 = 32'h7FFF_FFFF; req0_opnum2 = 32'h0000_0001; req0_func = ALU_FUNC_ADD;
    req0_valid = 1'b1; rsp0_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_req0_ready_eval: got %b expected 0", req0_ready); end
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp1_valid !== 1'b1 || rsp1_res !== 32'hF800_0000) begin errors++; $display("FAIL bp_hold_%0d: valid=%b res=%h expected 1 f8000000", c, rsp1_valid, rsp1_res); end
      checks++; if (req0_ready !== 1'b0 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL bp_port0_%0d: req0_ready=%b rsp0_valid=%b expected 0 0", c, req0_ready, rsp0_valid); end
      step();
    end
    rsp1_ready = 1'b1;
    #1;
    checks++; if (rsp1_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_at_accept: got %b expected 1", rsp1_valid); end
    step();
    rsp1_ready = 1'b0;
    #1;
    checks++; if (rsp1_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_after_accept: rsp1_valid=%b busy=%b expected 0 0", rsp1_valid, busy); end
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_req0_accept: got %b expected 1", req0_ready); end
    step();
    req0_valid = 1'b0;
    step();
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_res !== 32'h8000_0000) begin errors++; $display("FAIL bp_port0_result: valid=%b res=%h expected 1 80000000", rsp0_valid, rsp0_res); end
    step();
    rsp0_ready = 1'b0;
  endtask

  task automatic test_boundary();
    logic acc, vld;
    logic [DATA_W-1:0] res;
    drive_op0(32'h0000_0001, 32'h0000_0021, ALU_FUNC_SLL, acc, vld, res);
    checks++; if (acc !== 1'b1 || vld !== 1'b1 || res !== 32'h0000_0002) begin errors++; $display("FAIL sll_shamt5: acc=%b vld=%b res=%h expected 1 1 00000002", acc, vld, res); end
    drive_op0(32'h0000_0000, 32'hFFFF_FFFF, ALU_FUNC_SLTU, acc, vld, res);
    checks++; if (vld !== 1'b1 || res !== 32'h0000_0001) begin errors++; $display("FAIL sltu: vld=%b res=%h expected 1 00000001", vld, res); end
    drive_op0(32'h8000_0000, 32'h0000_003F, ALU_FUNC_SRL, acc, vld, res);
    checks++; if (vld !== 1'b1 || res !== 32'h0000_0001) begin errors++; $display("FAIL srl_shamt31: vld=%b res=%h expected 1 00000001", vld, res); end
    drive_op0(32'h0000_0005, 32'h0000_0003, 4'hF, acc, vld, res);
    checks++; if (vld !== 1'b1 || res !== 32'h0000_0000) begin errors++; $display("FAIL unknown_func: vld=%b res=%h expected 1 00000000", vld, res); end
    drive_op0(32'hF0F0_00FF, 32'h0FF0_0F0F, ALU_FUNC_XOR, acc, vld, res);
    checks++; if (vld !== 1'b1 || res !== 32'hFF00_0FF0) begin errors++; $display("FAIL xor: vld=%b res=%h expected 1 ff000ff0", vld, res); end
  endtask

  task automatic test_reset_mid_op();
    // Reset while in EVAL.
    req0_opnum1 = 32'd1; req0_opnum2 = 32'd1; req0_func = ALU_FUNC_ADD;
    req0_valid = 1'b1; rsp0_ready = 1'b0;
    step();
    req0_valid = 1'b0;
    #1;
    checks++; if (dbg.state !== ARB_EVAL) begin errors++; $display("FAIL midrst_in_eval: state=%0d expected %0d", dbg.state, ARB_EVAL); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (dbg.state !== ARB_IDLE || dbg.prio !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_eval_state: state=%0d prio=%b busy=%b expected IDLE 0 0", dbg.state, dbg.prio, busy); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL midrst_eval_no_rsp_%0d: got %b%b expected 00", c, rsp1_valid, rsp0_valid); end
    end
    // Reset while in RESP.
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    step();
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp0_res !== 32'd2) begin errors++; $display("FAIL midrst_in_resp: valid=%b res=%h expected 1 00000002", rsp0_valid, rsp0_res); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (rsp0_valid !== 1'b0 || rsp0_res !== '0) begin errors++; $display("FAIL midrst_resp_rsp: valid=%b res=%h expected 0 0", rsp0_valid, rsp0_res); end
    checks++; if (dbg.state !== ARB_IDLE || dbg.prio !== 1'b0) begin errors++; $display("FAIL midrst_resp_state: state=%0d prio=%b expected IDLE 0", dbg.state, dbg.prio); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_resp_quiet_%0d: valid=%b busy=%b expected 0 0", c, rsp0_valid, busy); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_boundary();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
